// File: rtl/dma_burst_master_pkg.sv
// ---------------------------------------------------------------------------
// dma_burst_master_pkg
//
// Purpose: definitions shared by the DMA burst master and its word buffer.
//          It holds the controller state encoding, the transfer direction
//          values, the default top-of-memory address and a helper that
//          word-aligns a byte address.
//
// Ports:   none (package)
//
// Configuration: DMA_NXM_EN (see dma_burst_master.sv) is the only option that
//          uses DEFAULT_MEM_TOP.
// ---------------------------------------------------------------------------
package dma_burst_master_pkg;

    // Controller states. IDLE must be the all-zero code so that reset and
    // the "not busy" decode agree.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } dma_state_t;

    // Values of the latched direction bit.
    localparam logic DIR_MEM_TO_DEV = 1'b0;
    localparam logic DIR_DEV_TO_MEM = 1'b1;

    // First non-existent byte address of a 28K-word memory.
    localparam logic [17:0] DEFAULT_MEM_TOP = 18'o160000;

    // Byte increment between consecutive 16-bit words.
    localparam logic [17:0] WORD_STEP = 18'd2;

    // Clears the byte-select bit so every memory cycle is word-aligned.
    function automatic logic [17:0] word_align(input logic [17:0] byte_addr);
        return {byte_addr[17:1], 1'b0};
    endfunction

endpackage

// File: rtl/dma_fifo.sv
// ---------------------------------------------------------------------------
// dma_fifo
//
// Purpose: small synchronous FIFO used as the word buffer between the device
//          stream and the memory bus. The read and write pointers are one bit
//          wider than the address so that full and empty can be told apart
//          without a separate counter. Full and empty are registered, computed
//          from the next-state pointers.
//
// Ports:
//   clk      in   clock
//   reset_n  in   asynchronous active-low reset
//   flush    in   discard all contents (takes priority over push/pop)
//   push     in   write wdata (ignored while full)
//   wdata    in   write data
//   pop      in   remove the head word (ignored while empty)
//   rdata    out  head word (only meaningful while not empty)
//   full     out  registered full flag
//   empty    out  registered empty flag
// ---------------------------------------------------------------------------
module dma_fifo
    import dma_burst_master_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_next;
    logic [AW:0]      rd_next;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // Next pointer values. A flush returns both pointers to zero, which
    // empties the buffer regardless of a simultaneous push or pop.
    always_comb begin
        wr_next = wr_ptr;
        rd_next = rd_ptr;
        if (flush) begin
            wr_next = '0;
            rd_next = '0;
        end else begin
            if (push_ok) begin
                wr_next = wr_ptr + (AW+1)'(1);
            end
            if (pop_ok) begin
                rd_next = rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Pointer and flag registers. Flags come from the next pointers so they
    // are valid in the same cycle the pointers settle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_next;
            rd_ptr <= rd_next;
            full   <= (wr_next[AW] != rd_next[AW]) &&
                      (wr_next[AW-1:0] == rd_next[AW-1:0]);
            empty  <= (wr_next == rd_next);
        end
    end

    // Storage array. No reset: a word is only ever read after it is written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/dma_burst_master.sv
// ---------------------------------------------------------------------------
// dma_burst_master
//
// Purpose: device-side DMA initiator for the I/O page. A controller loads a
//          start address, word count and direction; the block then moves
//          16-bit words between an internal buffer (dma_fifo) and main memory,
//          one memory cycle per granted ack cycle, until the count runs out,
//          the transfer is aborted, or a non-existent-memory condition stops
//          it.
//
// Parameters:
//   FIFO_DEPTH  buffer depth in words (power of two, >= 2)
//   MEM_TOP     first non-existent byte address (only with DMA_NXM_EN)
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   start, start_addr, start_wc, dir   transfer setup (latched when idle)
//   abort                        terminate the current transfer
//   busy, done, nxm, rem_wc      status
//   dev_wdata/dev_wvalid/dev_wready    device -> buffer stream
//   dev_rdata/dev_rvalid/dev_rready    buffer -> device stream
//   dma_req, dma_ack             bus request / grant
//   dma_addr, dma_rd, dma_wr     memory cycle address and strobes
//   dma_data_out, dma_data_in    memory write / read data
//
// Configuration macro: DMA_NXM_EN. When defined, an address at or above
// MEM_TOP stops the transfer and raises nxm. When undefined, nxm stays 0 and
// addresses are never checked.
// ---------------------------------------------------------------------------
module dma_burst_master
    import dma_burst_master_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [17:0] MEM_TOP    = DEFAULT_MEM_TOP
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [17:0] start_addr,
    input  logic [15:0] start_wc,
    input  logic        dir,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        nxm,
    output logic [15:0] rem_wc,
    input  logic [15:0] dev_wdata,
    input  logic        dev_wvalid,
    output logic        dev_wready,
    output logic [15:0] dev_rdata,
    output logic        dev_rvalid,
    input  logic        dev_rready,
    output logic        dma_req,
    input  logic        dma_ack,
    output logic [17:0] dma_addr,
    output logic        dma_rd,
    output logic        dma_wr,
    output logic [15:0] dma_data_out,
    input  logic [15:0] dma_data_in
);

    dma_state_t  state;
    dma_state_t  state_next;
    logic [17:0] cur_addr;
    logic [15:0] rem_cnt;
    logic        dir_q;
    logic        nxm_q;

    logic        fifo_flush;
    logic        fifo_push;
    logic        fifo_pop;
    logic [15:0] fifo_wdata;
    logic [15:0] fifo_rdata;
    logic        fifo_full;
    logic        fifo_empty;

    logic        active;
    logic        start_ok;
    logic        kill;
    logic        can_xfer_raw;
    logic        nxm_hit;
    logic        can_xfer;
    logic        strobe;
    logic        last_word;

    // Only the word address is used; the byte-select bit is dropped.
    logic        unused_addr_lsb;
    assign unused_addr_lsb = start_addr[0];

    assign active   = (state == ST_RUN) || (state == ST_DRAIN);
    assign start_ok = (state == ST_IDLE) && start;
    assign kill     = abort && active;

    // A memory cycle is possible when words remain and the buffer can supply
    // (write) or accept (read) one more word.
    assign can_xfer_raw = (state == ST_RUN) && (rem_cnt != 16'd0) &&
                          ((dir_q == DIR_DEV_TO_MEM) ? !fifo_empty : !fifo_full);

`ifdef DMA_NXM_EN
    // An attempt to touch memory above the top stops the transfer instead of
    // issuing a cycle that no memory would answer. Abort takes precedence.
    assign nxm_hit = can_xfer_raw && !kill && (cur_addr >= MEM_TOP);
`else
    assign nxm_hit = 1'b0;
    logic unused_mem_top;
    assign unused_mem_top = ^MEM_TOP;
`endif

    // Abort and NXM remove the request combinationally so that no strobe can
    // escape in the cycle they are seen.
    assign can_xfer  = can_xfer_raw && !kill && !nxm_hit;
    assign strobe    = can_xfer && dma_ack;
    assign last_word = strobe && (rem_cnt == 16'd1);

    assign dma_req  = can_xfer;
    assign dma_wr   = strobe && (dir_q == DIR_DEV_TO_MEM);
    assign dma_rd   = strobe && (dir_q == DIR_MEM_TO_DEV);
    assign dma_addr = cur_addr;
    assign rem_wc   = rem_cnt;
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_FIN);
    assign nxm      = nxm_q;

    // Device-side handshakes. Data outputs are forced to zero whenever the
    // buffer has nothing valid so they never show stale array contents.
    assign dev_wready   = (state == ST_RUN) && (dir_q == DIR_DEV_TO_MEM) && !fifo_full;
    assign dev_rvalid   = active && (dir_q == DIR_MEM_TO_DEV) && !fifo_empty;
    assign dev_rdata    = dev_rvalid ? fifo_rdata : 16'd0;
    assign dma_data_out = ((dir_q == DIR_DEV_TO_MEM) && !fifo_empty) ? fifo_rdata : 16'd0;

    // The buffer is filled from the device and drained by memory writes in
    // one direction, and the reverse in the other.
    assign fifo_push  = (dir_q == DIR_DEV_TO_MEM) ? (dev_wvalid && dev_wready) : dma_rd;
    assign fifo_wdata = (dir_q == DIR_DEV_TO_MEM) ? dev_wdata : dma_data_in;
    assign fifo_pop   = (dir_q == DIR_DEV_TO_MEM) ? dma_wr : (dev_rvalid && dev_rready);
    assign fifo_flush = start_ok || kill || nxm_hit;

    dma_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (fifo_flush),
        .push    (fifo_push),
        .wdata   (fifo_wdata),
        .pop     (fifo_pop),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A read transfer finishes its memory cycles in RUN and
    // then waits in DRAIN until the device has taken every buffered word.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = (start_wc != 16'd0) ? ST_RUN : ST_FIN;
                end
            end
            ST_RUN: begin
                if (kill || nxm_hit) begin
                    state_next = ST_FIN;
                end else if (last_word) begin
                    state_next = (dir_q == DIR_DEV_TO_MEM) ? ST_FIN : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (kill || fifo_empty) begin
                    state_next = ST_FIN;
                end
            end
            ST_FIN: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Transfer bookkeeping: the address and remaining count are loaded on an
    // accepted start and stepped once per memory strobe. The NXM flag is
    // cleared by start and set by an out-of-range attempt.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_addr <= 18'd0;
            rem_cnt  <= 16'd0;
            dir_q    <= DIR_MEM_TO_DEV;
            nxm_q    <= 1'b0;
        end else if (start_ok) begin
            cur_addr <= word_align(start_addr);
            rem_cnt  <= start_wc;
            dir_q    <= dir;
            nxm_q    <= 1'b0;
        end else begin
            if (strobe) begin
                cur_addr <= cur_addr + WORD_STEP;
                rem_cnt  <= rem_cnt - 16'd1;
            end
            if (nxm_hit) begin
                nxm_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dma_burst_master.sv
// ---------------------------------------------------------------------------
// tb_dma_burst_master
//
// Purpose: self-checking bench for dma_burst_master. Each transfer is
//          predicted from the block's rules: the n-th memory cycle goes to
//          start + 2n (mod 2^18), write cycles carry the device words in push
//          order, read cycles deliver memory words to the device in address
//          order, and the number of cycles is the word count, cut short by
//          abort or (with DMA_NXM_EN) by the first address at or above
//          MEM_TOP. The arbiter, device and memory are modelled with random
//          timing.
//
// Ports:   none (top-level bench)
// ---------------------------------------------------------------------------
module tb_dma_burst_master;

    localparam int          FIFO_DEPTH = 4;
    localparam logic [17:0] MEM_TOP    = 18'o160000;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [17:0] start_addr;
    logic [15:0] start_wc;
    logic        dir;
    logic        abort;
    logic        busy;
    logic        done;
    logic        nxm;
    logic [15:0] rem_wc;
    logic [15:0] dev_wdata;
    logic        dev_wvalid;
    logic        dev_wready;
    logic [15:0] dev_rdata;
    logic        dev_rvalid;
    logic        dev_rready;
    logic        dma_req;
    logic        dma_ack;
    logic [17:0] dma_addr;
    logic        dma_rd;
    logic        dma_wr;
    logic [15:0] dma_data_out;
    logic [15:0] dma_data_in;

    int          numChecks;
    int          numFails;
    logic [15:0] salt;

    dma_burst_master #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .MEM_TOP    (MEM_TOP)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .start_addr   (start_addr),
        .start_wc     (start_wc),
        .dir          (dir),
        .abort        (abort),
        .busy         (busy),
        .done         (done),
        .nxm          (nxm),
        .rem_wc       (rem_wc),
        .dev_wdata    (dev_wdata),
        .dev_wvalid   (dev_wvalid),
        .dev_wready   (dev_wready),
        .dev_rdata    (dev_rdata),
        .dev_rvalid   (dev_rvalid),
        .dev_rready   (dev_rready),
        .dma_req      (dma_req),
        .dma_ack      (dma_ack),
        .dma_addr     (dma_addr),
        .dma_rd       (dma_rd),
        .dma_wr       (dma_wr),
        .dma_data_out (dma_data_out),
        .dma_data_in  (dma_data_in)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Contents of the simulated main memory at a byte address.
    function automatic logic [15:0] memWord(input logic [17:0] a);
        return a[16:1] ^ 16'hC3A5 ^ salt;
    endfunction

    // Runs one transfer with random arbiter/device timing and checks it.
    // abortAt >= 0 aborts during the ack cycle that would carry word abortAt.
    // holdCycles > 0 keeps dev_rready low for that many cycles and then checks
    // that the master stalled on a full buffer.
    task automatic applyStimulus(input logic d, input logic [17:0] a,
                                 input int wc, input int abortAt,
                                 input int holdCycles, input int ackPct);
        logic [15:0] words[$];
        logic [17:0] base;
        logic [17:0] expAddr;
        int          expN;
        bit          expNxm;
        int          widx, ridx, strobes, cyc, burst, abortCycle, expHold;
        bit          lastReq, aborted, finished, reqSeen;

        base = {a[17:1], 1'b0};
        words.delete();
        for (int i = 0; i < wc; i++) words.push_back(16'($urandom));
        expN   = wc;
        expNxm = 1'b0;
`ifdef DMA_NXM_EN
        for (int i = 0; i < wc; i++) begin
            expAddr = base + 18'(2 * i);
            if (expAddr >= MEM_TOP) begin
                expN   = i;
                expNxm = 1'b1;
                break;
            end
        end
`endif
        if (abortAt >= 0) expN = abortAt;
        expHold = (wc < FIFO_DEPTH) ? wc : FIFO_DEPTH;

        widx = 0; ridx = 0; strobes = 0; cyc = 0; burst = 0; abortCycle = -1;
        lastReq = 0; aborted = 0; finished = 0; reqSeen = 0;

        @(negedge clk);
        start      = 1'b1;
        start_addr = a;
        start_wc   = 16'(wc);
        dir        = d;
        @(negedge clk);
        start      = 1'b0;
        start_addr = 18'($urandom);
        start_wc   = 16'($urandom);
        dir        = 1'($urandom);
        checkOutput("busy_after_start", busy, 1);
        checkOutput("nxm_cleared", nxm, 0);

        while (!finished && cyc < 3000) begin
            if (lastReq && burst < 4 && $urandom_range(99) < ackPct) begin
                dma_ack = 1'b1;
                burst++;
            end else begin
                dma_ack = 1'b0;
                burst = 0;
            end
            dev_wvalid  = d && (widx < wc) && ($urandom_range(99) < 70);
            dev_wdata   = dev_wvalid ? words[widx] : 16'($urandom);
            dev_rready  = (cyc < holdCycles) ? 1'b0 : ($urandom_range(99) < 70);
            abort       = (abortAt >= 0) && !aborted && (strobes == abortAt) && dma_ack;
            dma_data_in = memWord(dma_addr);
            #1;
            if (dma_req) reqSeen = 1;
            if (holdCycles > 0 && cyc == holdCycles) begin
                checkOutput("hold_strobes", strobes, expHold);
                checkOutput("hold_req_low", dma_req, 0);
            end
            if (dma_wr || dma_rd) begin
                checkOutput("strobe_dir", {dma_wr, dma_rd}, d ? 2'b10 : 2'b01);
                checkOutput("strobe_ack", dma_ack, 1);
                checkOutput("strobe_in_range", strobes < expN, 1);
                if (strobes < wc) begin
                    expAddr = base + 18'(2 * strobes);
                    checkOutput("mem_addr", dma_addr, expAddr);
                    if (d) checkOutput("mem_wdata", dma_data_out, words[strobes]);
                end
                strobes++;
            end
            if (abort) begin
                aborted    = 1;
                abortCycle = cyc;
                checkOutput("abort_no_strobe", dma_wr | dma_rd, 0);
                checkOutput("abort_no_req", dma_req, 0);
            end
            if (dev_wvalid && dev_wready) widx++;
            if (dev_rvalid && dev_rready) begin
                expAddr = base + 18'(2 * ridx);
                checkOutput("dev_rdata", dev_rdata, memWord(expAddr));
                ridx++;
            end
            if (done) begin
                finished = 1;
                checkOutput("done_strobes", strobes, expN);
                checkOutput("done_rem_wc", rem_wc, 16'(wc - expN));
                checkOutput("done_nxm", nxm, expNxm);
                checkOutput("done_busy", busy, 1);
                if (abortAt >= 0) begin
                    checkOutput("abort_fired", aborted, 1);
                    checkOutput("abort_done_latency", cyc, abortCycle + 1);
                end else if (!d && !expNxm) begin
                    checkOutput("read_delivered", ridx, wc);
                end
                if (wc == 0) checkOutput("wc0_no_req", reqSeen, 0);
            end
            lastReq = dma_req;
            cyc++;
            if (!finished) @(negedge clk);
        end
        if (!finished) checkOutput("done_timeout", 0, 1);

        @(negedge clk);
        abort      = 1'b0;
        dma_ack    = 1'b0;
        dev_wvalid = 1'b0;
        dev_rready = 1'b0;
        #1;
        checkOutput("idle_busy", busy, 0);
        checkOutput("done_one_cycle", done, 0);
    endtask

    initial begin
        numChecks  = 0;
        numFails   = 0;
        salt       = 16'($urandom);
        reset_n    = 1'b0;
        start      = 1'b0;
        start_addr = 18'd0;
        start_wc   = 16'd0;
        dir        = 1'b0;
        abort      = 1'b0;
        dev_wdata  = 16'd0;
        dev_wvalid = 1'b0;
        dev_rready = 1'b0;
        dma_ack    = 1'b0;
        dma_data_in = 16'd0;

        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_nxm", nxm, 0);
        checkOutput("reset_rem_wc", rem_wc, 0);
        checkOutput("reset_dma_req", dma_req, 0);
        checkOutput("reset_strobes", {dma_rd, dma_wr}, 0);
        checkOutput("reset_dma_addr", dma_addr, 0);
        checkOutput("reset_dev_hs", {dev_wready, dev_rvalid}, 0);
        checkOutput("reset_data", {dev_rdata, dma_data_out}, 0);
        @(negedge clk);
        reset_n = 1'b1;

        $display("[TB] directed transfers");
        applyStimulus(1'b1, 18'o1000,   3,  -1, 0,  100);
        applyStimulus(1'b0, 18'o2000,   6,  -1, 12, 100);
        applyStimulus(1'b0, 18'o3000,   0,  -1, 0,  100);
        applyStimulus(1'b1, 18'o4000,   10, 4,  0,  100);
        applyStimulus(1'b0, 18'o4400,   10, 3,  0,  80);
        applyStimulus(1'b1, 18'o777776, 2,  -1, 0,  100);
        applyStimulus(1'b0, 18'o777777, 2,  -1, 0,  100);
`ifdef DMA_NXM_EN
        applyStimulus(1'b1, 18'o157776, 2,  -1, 0,  100);
        applyStimulus(1'b0, 18'o157774, 5,  -1, 0,  100);
`endif

        $display("[TB] random transfers");
        for (int t = 0; t < 30; t++) begin
            logic        rd;
            logic [17:0] ra;
            int          rwc;
            int          rab;
            rd  = 1'($urandom);
`ifdef DMA_NXM_EN
            ra  = 18'($urandom_range(0, 18'o157000));
`else
            ra  = 18'($urandom);
`endif
            rwc = $urandom_range(0, 9);
            rab = (rwc > 0 && $urandom_range(3) == 0) ? $urandom_range(0, rwc - 1) : -1;
            applyStimulus(rd, ra, rwc, rab, 0, $urandom_range(30, 100));
        end

        $display("[TB] reset during transfer");
        @(negedge clk);
        start      = 1'b1;
        start_addr = 18'o6000;
        start_wc   = 16'd8;
        dir        = 1'b0;
        @(negedge clk);
        start      = 1'b0;
        dma_ack    = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("midreset_busy", busy, 0);
        checkOutput("midreset_done", done, 0);
        checkOutput("midreset_rem_wc", rem_wc, 0);
        checkOutput("midreset_dma_addr", dma_addr, 0);
        checkOutput("midreset_req", dma_req, 0);
        checkOutput("midreset_rvalid", dev_rvalid, 0);
        @(negedge clk);
        dma_ack = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("postreset_busy", busy, 0);
        checkOutput("postreset_done", done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
